// File: rtl/sound_arbiter.sv
// sound_arbiter: edge-triggered, fixed-priority sound channel arbiter with
// preemption and a per-channel play duration.
// Ports: clk, reset (sync, active-high); trig[N_CH] level requests;
//   dur[N_CH*TIMER_W] per-channel durations (dur_i+1 cycles);
//   ch_sound[N_CH] tone inputs; ch_enable one-hot tone enable;
//   sound speaker bit; busy (PLAY/GAP); active_ch; pending queue bits.
// Optional macro AUDIO_PENDING_EN: one-deep replay queue per channel.
module sound_arbiter #(
    parameter int N_CH    = 4,
    parameter int TIMER_W = 24,
    parameter int GAP_CYC = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_CH-1:0]           trig,
    input  logic [N_CH*TIMER_W-1:0]   dur,
    input  logic [N_CH-1:0]           ch_sound,
    output logic [N_CH-1:0]           ch_enable,
    output logic                      sound,
    output logic                      busy,
    output logic [$clog2(N_CH)-1:0]   active_ch,
    output logic [N_CH-1:0]           pending
);

    localparam int CH_W  = $clog2(N_CH);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
`ifdef AUDIO_PENDING_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [CH_W-1:0]      active_q, active_d;
    logic [N_CH-1:0]      trig_prev_q;
    logic [N_CH-1:0]      pend_cur, pend_d;

    logic [N_CH-1:0]      trig_edge, win_oh, queued, pend_all;
    logic [CH_W-1:0]      win, hp, start_ch;
    logic                 any_edge, preempt, start;

    function automatic logic [CH_W-1:0] highest(input logic [N_CH-1:0] v);
        highest = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (v[i]) highest = CH_W'(i);
        end
    endfunction

    function automatic logic [TIMER_W-1:0] dur_of(input logic [CH_W-1:0] ch);
        dur_of = dur[ch*TIMER_W +: TIMER_W];
    endfunction

    assign trig_edge = trig & ~trig_prev_q;
    assign any_edge  = |trig_edge;
    assign win       = highest(trig_edge);
    assign win_oh    = N_CH'(1) << win;

    // Outside PLAY every edge starts a sound; inside PLAY only equal or
    // higher priority may take over.
    assign preempt   = any_edge && (state_q != PLAY || win >= active_q);
    assign queued    = !PEN ? '0 :
                       preempt ? (trig_edge & ~win_oh) : trig_edge;
    assign pend_all  = pend_cur | queued;
    assign hp        = highest(pend_all);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        gap_d    = gap_q;
        active_d = active_q;
        start    = 1'b0;
        start_ch = win;
        unique case (state_q)
            IDLE: begin
                if (preempt) start = 1'b1;
            end
            PLAY: begin
                if (preempt) begin
                    start = 1'b1;
                end else if (timer_q == '0) begin
                    if (|pend_all) begin
                        if (GAP_CYC > 0) begin
                            state_d = GAP;
                            gap_d   = GAP_W'(GAP_CYC - 1);
                        end else begin
                            start    = 1'b1;
                            start_ch = hp;
                        end
                    end else begin
                        state_d  = IDLE;
                        active_d = '0;
                    end
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            GAP: begin
                if (preempt) begin
                    start = 1'b1;
                end else if (gap_q == '0) begin
                    start    = 1'b1;
                    start_ch = hp;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                active_d = '0;
            end
        endcase
        if (start) begin
            state_d  = PLAY;
            active_d = start_ch;
            timer_d  = dur_of(start_ch);
        end
        pend_d = pend_all & ~(start ? (N_CH'(1) << start_ch) : '0);
    end

    always_ff @(posedge clk) begin
        // Tracking trig through reset keeps a held trigger from firing.
        trig_prev_q <= trig;
        if (reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            gap_q    <= '0;
            active_q <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            gap_q    <= gap_d;
            active_q <= active_d;
        end
    end

`ifdef AUDIO_PENDING_EN
    logic [N_CH-1:0] pending_q;
    always_ff @(posedge clk) begin
        if (reset) pending_q <= '0;
        else       pending_q <= pend_d;
    end
    assign pend_cur = pending_q;
`else
    logic unused_pend;
    assign unused_pend = ^pend_d;
    assign pend_cur    = '0;
`endif

    assign pending   = pend_cur;
    assign busy      = (state_q != IDLE);
    assign active_ch = active_q;
    assign ch_enable = (state_q == PLAY) ? (N_CH'(1) << active_q) : '0;
    assign sound     = (state_q == PLAY) & ch_sound[active_q];

endmodule

// File: doc/sound_arbiter.md
# sound_arbiter

Parametrised successor to the game's single-slot sound selector. It accepts N_CH level-type trigger lines, which include jump, win, lose and any future effects. Each trigger is rising-edge detected, channels are arbitrated by fixed priority with preemption, and the winning tone generator is enabled for a programmable duration. Lower-priority requests can optionally be held and replayed afterwards. The block sits between the game FSM/input logic and the per-effect tone generators, and drives the single speaker bit.

## Interface
- N_CH, 4: number of sound channels; channel index = priority, highest index wins.
- TIMER_W, 24: width of the duration counter and of each duration field.
- GAP_CYC, 0: silent cycles between a finished sound and a queued one; 0 = back-to-back.

- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- trig  in  N_CH  level request per channel; a 0->1 transition is a play request.
- dur  in  N_CH*TIMER_W  per-channel duration; field i = dur[i*TIMER_W +: TIMER_W]; sound plays dur_i+1 cycles.
- ch_sound  in  N_CH  tone-generator outputs.
- ch_enable  out  N_CH  one-hot enable to tone generators; all-zero when silent.
- sound  out  1  ch_sound[active_ch] while playing, else 0.
- busy  out  1  high in PLAY or GAP.
- active_ch  out  $clog2(N_CH)  index of the playing channel; 0 when idle.
- pending  out  N_CH  queued-request bits; always 0 when AUDIO_PENDING_EN is undefined.

## Operation
- Edge detect: `trig_prev` is registered each cycle. `edge[i] = trig[i] & ~trig_prev[i]`.
- States:
  - IDLE: silent.
  - PLAY: ch_enable[active_ch]=1; timer counts down.
  - GAP: silent; gap counter counts down.
- Winner: highest-index set bit of edge.
- IDLE + any edge -> PLAY on the winner; timer <= dur_winner.
- PLAY + edge with winner >= active_ch -> preempt. active_ch <= winner and timer reloads. A same-channel retrigger restarts that channel.
- PLAY + edge with winner < active_ch -> the request is blocked.
  - With the macro: pending[winner] <= 1.
  - Without the macro: the request is dropped.
- Losing simultaneous edges are treated like blocked requests: queued with the macro, dropped without it.
- PLAY, timer==0, no edge:
  - If pending is nonzero and GAP_CYC>0 -> GAP for GAP_CYC cycles.
  - If pending is nonzero and GAP_CYC==0 -> PLAY on the highest pending channel directly.
  - If pending is zero -> IDLE.
- GAP end -> PLAY on the highest pending channel.
- GAP + edge -> abandon the gap and PLAY on the winner. Any blocked edges are queued per the rules above.
- When a channel starts playing by any path, its pending bit clears that same edge.
- Arithmetic: the timer decrements by 1 with no wrap. It is never decremented from 0.

## Timing
- Reset:
  - state=IDLE; timer=0; pending=0; active_ch=0.
  - ch_enable=0, sound=0, busy=0 from the first cycle after the reset edge.
  - trig_prev <= trig during reset, so a trigger held high through reset does not fire.
- Latency: trig rises before edge k; ch_enable and busy are high from edge k to edge k+dur+1. That is dur+1 cycles.
- Outputs are combinational decodes of registered state. sound has a pure mux delay from ch_sound.
- Reset mid-PLAY silences all outputs on the next cycle and discards pending.
- Back-to-back requires GAP_CYC=0: the last cycle of sound A is directly followed by the first cycle of queued sound B, with no idle cycle.

## Configuration
- AUDIO_PENDING_EN defined:
  - one-deep pending bit per channel.
  - blocked and losing simultaneous requests replay later in priority order.
  - GAP state is used.
- AUDIO_PENDING_EN undefined:
  - no pending register; pending output is tied to 0.
  - blocked requests are discarded.
  - PLAY always ends in IDLE; GAP is unreachable.

## Test plan
- Basic play: N_CH=4, dur0=5, pulse trig[0] -> ch_enable=4'b0001 for exactly 6 cycles, sound follows ch_sound[0], then IDLE with busy=0.
- Preempt: ch0 playing with dur0=100; at cycle 10 raise trig[3] with dur3=20 -> ch_enable=4'b1000 for 21 cycles, then IDLE. With the macro, pending[0]=0 throughout: preempted sounds are not resumed.
- Blocked plus queue (macro on, GAP_CYC=2): ch2 playing; trig[1] rises -> pending=4'b0010; ch2 ends -> 2 silent cycles -> ch1 plays dur1+1 cycles, then pending=0.
- Simultaneous edges trig[1] and trig[2] at the same edge, GAP_CYC=0, macro on -> ch2 plays first, then ch1 starts the very next cycle. With the macro off, only ch2 plays.
- Retrigger and hold: trig[2] held high for 50 cycles with dur2=10 -> exactly one 11-cycle sound. A low-to-high toggle at cycle 5 restarts the timer, giving 11 cycles from the retrigger.
- Reset mid-play: assert reset during PLAY with trig[0] held high -> all outputs 0 next cycle. After deassertion there is no replay until trig[0] toggles.
